// File: rtl/ripple_adder.sv
// Ripple-carry adder. A chain of full-adder stages computes A + B + C_in,
// and output registers capture the sum and carry-out on every rising clock edge.
module ripple_adder #(
    parameter int unsigned data_width = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [data_width-1:0] A,
    input  logic [data_width-1:0] B,
    input  logic                  C_in,
    output logic                  C_out,
    output logic [data_width-1:0] Sum
);

    // carry[i] is the carry into stage i. carry[data_width] is the carry-out.
    logic [data_width:0]   carry_c;
    logic [data_width-1:0] sum_c;

    assign carry_c[0] = C_in;

    // One full-adder stage per bit. The carry ripples from the LSB to the MSB.
    for (genvar i = 0; i < data_width; i++) begin : g_stage
        assign sum_c[i]     = A[i] ^ B[i] ^ carry_c[i];
        assign carry_c[i+1] = (A[i] & B[i]) | (A[i] & carry_c[i]) | (B[i] & carry_c[i]);
    end

    // Register the ripple result. Reset clears the outputs asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Sum   <= '0;
            C_out <= 1'b0;
        end else begin
            Sum   <= sum_c;
            C_out <= carry_c[data_width];
        end
    end

endmodule

// File: tb/tb_ripple_adder.sv
// Bench for ripple_adder. It runs an 8-bit instance and a 4-bit instance side by side.
// Each one has a scoreboard queue that holds the expected {C_out, Sum} results.
module tb_ripple_adder;

    logic       clk;
    logic       rst_n;
    logic [7:0] a8, b8, sum8;
    logic       cin8, cout8;
    logic [3:0] a4, b4, sum4;
    logic       cin4, cout4;

    logic [8:0] q8[$];
    logic [8:0] q4[$];
    int         compared   = 0;
    int         mismatched = 0;

    ripple_adder #(.data_width(8)) u_dut8 (
        .clk  (clk),
        .rst_n(rst_n),
        .A    (a8),
        .B    (b8),
        .C_in (cin8),
        .C_out(cout8),
        .Sum  (sum8)
    );

    ripple_adder #(.data_width(4)) u_dut4 (
        .clk  (clk),
        .rst_n(rst_n),
        .A    (a4),
        .B    (b4),
        .C_in (cin4),
        .C_out(cout4),
        .Sum  (sum4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic c);
        return 9'({1'b0, x} + {1'b0, y} + 9'(c));
    endfunction

    function automatic logic [8:0] ref4(input logic [3:0] x, input logic [3:0] y, input logic c);
        return 9'({1'b0, x} + {1'b0, y} + 5'(c));
    endfunction

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Apply one vector to both instances and queue the expected results.
    task automatic drive(input logic [7:0] xa8, input logic [7:0] xb8, input logic xc8,
                         input logic [3:0] xa4, input logic [3:0] xb4, input logic xc4);
        a8 = xa8; b8 = xb8; cin8 = xc8;
        a4 = xa4; b4 = xb4; cin4 = xc4;
        q8.push_back(ref8(xa8, xb8, xc8));
        q4.push_back(ref4(xa4, xb4, xc4));
    endtask

    // After the next rising edge, pop one expected result per instance and compare.
    task automatic sample(input string tag);
        logic [8:0] e8;
        logic [8:0] e4;
        @(posedge clk);
        #1;
        if (q8.size() == 0 || q4.size() == 0) begin
            check({tag, "_queue"}, 9'h000, 9'h1ff);
        end else begin
            e8 = q8.pop_front();
            e4 = q4.pop_front();
            check({tag, "_w8"}, {cout8, sum8}, e8);
            check({tag, "_w4"}, {4'b0, cout4, sum4}, e4);
        end
    endtask

    task automatic cycle(input string tag,
                         input logic [7:0] xa8, input logic [7:0] xb8, input logic xc8,
                         input logic [3:0] xa4, input logic [3:0] xb4, input logic xc4);
        @(negedge clk);
        drive(xa8, xb8, xc8, xa4, xb4, xc4);
        sample(tag);
    endtask

    initial begin
        // Hold reset with arbitrary inputs while the clock runs.
        rst_n = 1'b0;
        a8 = 8'h5a; b8 = 8'hc3; cin8 = 1'b1;
        a4 = 4'h9;  b4 = 4'h6;  cin4 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_w8", {cout8, sum8}, 9'h000);
        check("reset_w4", {4'b0, cout4, sum4}, 9'h000);

        // Release reset. The first edge afterwards loads the current inputs.
        @(negedge clk);
        rst_n = 1'b1;
        drive(8'haa, 8'h55, 1'b0, 4'ha, 4'h5, 1'b0);
        sample("no_carry");

        // Apply back-to-back vectors, one per cycle.
        cycle("full_ripple", 8'hff, 8'h00, 1'b1, 4'hf, 4'h0, 1'b1);
        cycle("mixed",       8'hfc, 8'h07, 1'b1, 4'hc, 4'h7, 1'b1);
        cycle("max",         8'hff, 8'hff, 1'b1, 4'hf, 4'hf, 1'b1);

        // Change the inputs between edges. The outputs must keep the previous result.
        #2;
        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        a4 = 4'h0;  b4 = 4'h0;  cin4 = 1'b0;
        #1;
        check("hold_w8", {cout8, sum8}, 9'h1ff);
        check("hold_w4", {4'b0, cout4, sum4}, 9'h01f);

        // Assert reset mid-stream between edges. Its effect must be immediate.
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
        a4 = 4'h3;  b4 = 4'h4;  cin4 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_w8", {cout8, sum8}, 9'h000);
        check("async_rst_w4", {4'b0, cout4, sum4}, 9'h000);

        // The pending add is discarded, and the outputs stay at zero across an edge.
        @(posedge clk);
        #1;
        check("rst_hold_w8", {cout8, sum8}, 9'h000);
        check("rst_hold_w4", {4'b0, cout4, sum4}, 9'h000);

        @(negedge clk);
        rst_n = 1'b1;
        drive(8'h12, 8'h34, 1'b0, 4'h3, 4'h4, 1'b0);
        sample("post_rst");

        // Exhaustive test of the 4-bit instance. The 8-bit instance gets random operands.
        for (int i = 0; i < 512; i++) begin
            cycle("exh", 8'($urandom), 8'($urandom), 1'($urandom),
                  4'(i >> 5), 4'(i >> 1), 1'(i));
        end

        // Random vectors on both instances.
        for (int i = 0; i < 10000; i++) begin
            cycle("rand", 8'($urandom), 8'($urandom), 1'($urandom),
                  4'($urandom), 4'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
